// File: rtl/eight_to_one_mux_16_bit_if.sv
// Bus bundle for the registered 8:1 x 16-bit mux.
// Carries the eight data words, the select bits, Enable and the output Y.
interface eight_to_one_mux_16_bit_if;
  logic [15:0] I0;
  logic [15:0] I1;
  logic [15:0] I2;
  logic [15:0] I3;
  logic [15:0] I4;
  logic [15:0] I5;
  logic [15:0] I6;
  logic [15:0] I7;
  logic        S0;
  logic        S1;
  logic        S2;
  logic        Enable;
  logic [15:0] Y;

  modport master (
    output I0, I1, I2, I3,
    output I4, I5, I6, I7,
    output S0, S1, S2, Enable,
    input  Y
  );

  modport slave (
    input  I0, I1, I2, I3,
    input  I4, I5, I6, I7,
    input  S0, S1, S2, Enable,
    output Y
  );
endinterface

// File: rtl/eight_to_one_mux_16_bit.sv
// Registered 8:1 mux, 16-bit words, active-high Enable (0 forces zero).
// Ports: clk, rst_n (async, active-low), bus (slave: I0..I7, S2..S0, Enable in; Y out).
module eight_to_one_mux_16_bit (
  input  logic                      clk,
  input  logic                      rst_n,
  eight_to_one_mux_16_bit_if.slave  bus
);

  logic [2:0]  sel;
  logic [15:0] y_d;
  logic [15:0] y_q;

  assign sel = {bus.S2, bus.S1, bus.S0};

  always_comb begin
    y_d = 16'h0000;
    if (bus.Enable) begin
      unique case (sel)
        3'd0: y_d = bus.I0;
        3'd1: y_d = bus.I1;
        3'd2: y_d = bus.I2;
        3'd3: y_d = bus.I3;
        3'd4: y_d = bus.I4;
        3'd5: y_d = bus.I5;
        3'd6: y_d = bus.I6;
        3'd7: y_d = bus.I7;
        default: y_d = 16'h0000;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) y_q <= 16'h0000;
    else        y_q <= y_d;
  end

  assign bus.Y = y_q;

endmodule

// File: tb/tb_eight_to_one_mux_16_bit.sv
// Self-checking bench for the registered 8:1 x 16-bit mux.
// Reference model: expected Y = en ? din[sel] : 0, one edge later.
module tb_eight_to_one_mux_16_bit;

  logic clk;
  logic rst_n;
  int   vectors;
  int   errs;

  logic [15:0] din [8];
  logic [2:0]  sel;
  logic        en;
  logic [15:0] exp_y;

  eight_to_one_mux_16_bit_if bus ();

  eight_to_one_mux_16_bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] model();
    return en ? din[sel] : 16'h0000;
  endfunction

  task automatic drive();
    bus.I0 = din[0];
    bus.I1 = din[1];
    bus.I2 = din[2];
    bus.I3 = din[3];
    bus.I4 = din[4];
    bus.I5 = din[5];
    bus.I6 = din[6];
    bus.I7 = din[7];
    {bus.S2, bus.S1, bus.S0} = sel;
    bus.Enable = en;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) din[i] = 16'h0;
    din[3] = 16'h0003;
    sel = 3'd3;
    en  = 1'b1;
    drive();
    #1;
    vectors++;
    if (bus.Y !== 16'h0000) begin
      errs++;
      $display("FAIL reset_hold got=%h exp=%h", bus.Y, 16'h0000);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      vectors++;
      if (bus.Y !== 16'h0000) begin
        errs++;
        $display("FAIL reset_edge%0d got=%h exp=%h", k, bus.Y, 16'h0000);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.Y !== 16'h0003) begin
      errs++;
      $display("FAIL reset_release got=%h exp=%h", bus.Y, 16'h0003);
    end
  endtask

  task automatic test_sel_sweep();
    for (int i = 0; i < 8; i++) din[i] = 16'(i);
    en = 1'b1;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      sel = 3'(s);
      drive();
      exp_y = 16'(s);
      tick();
      vectors++;
      if (bus.Y !== exp_y) begin
        errs++;
        $display("FAIL sweep sel=%0d got=%h exp=%h", s, bus.Y, exp_y);
      end
    end
  endtask

  task automatic test_full_width();
    logic [2:0] picks [2];
    logic [15:0] want [2];
    for (int i = 0; i < 8; i++) din[i] = 16'h0;
    din[5] = 16'hA5C3;
    din[2] = 16'hFFFF;
    picks[0] = 3'd5; want[0] = 16'hA5C3;
    picks[1] = 3'd2; want[1] = 16'hFFFF;
    en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      sel = picks[k];
      drive();
      tick();
      vectors++;
      if (bus.Y !== want[k]) begin
        errs++;
        $display("FAIL full_width sel=%0d got=%h exp=%h", picks[k], bus.Y, want[k]);
      end
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 8; i++) din[i] = 16'(i) | 16'hF0F0;
    din[7] = 16'h0007;
    @(negedge clk);
    sel = 3'd7;
    en  = 1'b1;
    drive();
    tick();
    vectors++;
    if (bus.Y !== 16'h0007) begin
      errs++;
      $display("FAIL enable_on got=%h exp=%h", bus.Y, 16'h0007);
    end
    @(negedge clk);
    en = 1'b0;
    drive();
    tick();
    vectors++;
    if (bus.Y !== 16'h0000) begin
      errs++;
      $display("FAIL enable_off got=%h exp=%h", bus.Y, 16'h0000);
    end
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      sel = 3'(s);
      drive();
      tick();
      vectors++;
      if (bus.Y !== 16'h0000) begin
        errs++;
        $display("FAIL enable_off sel=%0d got=%h exp=%h", s, bus.Y, 16'h0000);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) din[i] = 16'(i);
    @(negedge clk);
    sel = 3'd6;
    en  = 1'b1;
    drive();
    tick();
    vectors++;
    if (bus.Y !== 16'h0006) begin
      errs++;
      $display("FAIL async_pre got=%h exp=%h", bus.Y, 16'h0006);
    end
    #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.Y !== 16'h0000) begin
      errs++;
      $display("FAIL async_clear got=%h exp=%h", bus.Y, 16'h0000);
    end
    #1;
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.Y !== 16'h0000) begin
      errs++;
      $display("FAIL async_hold got=%h exp=%h", bus.Y, 16'h0000);
    end
    tick();
    vectors++;
    if (bus.Y !== 16'h0006) begin
      errs++;
      $display("FAIL async_reload got=%h exp=%h", bus.Y, 16'h0006);
    end
  endtask

  task automatic test_registered();
    for (int i = 0; i < 8; i++) din[i] = 16'h1000 + 16'(i);
    @(negedge clk);
    sel = 3'd1;
    en  = 1'b1;
    drive();
    tick();
    vectors++;
    if (bus.Y !== 16'h1001) begin
      errs++;
      $display("FAIL reg_first got=%h exp=%h", bus.Y, 16'h1001);
    end
    sel = 3'd4;
    drive();
    #2;
    vectors++;
    if (bus.Y !== 16'h1001) begin
      errs++;
      $display("FAIL reg_between got=%h exp=%h", bus.Y, 16'h1001);
    end
    tick();
    vectors++;
    if (bus.Y !== 16'h1004) begin
      errs++;
      $display("FAIL reg_next got=%h exp=%h", bus.Y, 16'h1004);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++) din[i] = 16'($urandom);
      sel = 3'($urandom_range(0, 7));
      en  = ($urandom_range(0, 3) != 0);
      drive();
      exp_y = model();
      tick();
      vectors++;
      if (bus.Y !== exp_y) begin
        errs++;
        $display("FAIL b2b n=%0d sel=%0d en=%0b got=%h exp=%h",
                 n, sel, en, bus.Y, exp_y);
      end
    end
  endtask

  initial begin
    vectors = 0;
    errs    = 0;
    test_reset();
    test_sel_sweep();
    test_full_width();
    test_enable();
    test_async_reset();
    test_registered();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
